// File: rtl/lru_key_queue.sv
// lru_key_queue: keyed, LRU-ordered buffer of DEPTH entries (key + payload).
// Push inserts or refreshes an entry at MRU, touch promotes a matching entry
// to MRU, and pop removes the LRU entry. ord_q holds slot indices from LRU
// (position 0) to MRU (position size-1).
// An insert while full and not popping is dropped, and so is the rest of that
// cycle's update. A pop while empty is ignored.
// Optional macro LRU_KEY_QUEUE_PERF_EN adds touch-hit, touch-miss and refresh
// event counters.
module lru_key_queue #(
   parameter int DATAW    = 32,
   parameter int KEYW     = 16,
   parameter int DEPTH    = 4,
   parameter int ALM_FULL = DEPTH - 1,
   parameter int SIZEW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [KEYW-1:0]  push_key,
   input  logic [DATAW-1:0] push_data,
   input  logic             pop,
   input  logic             touch,
   input  logic [KEYW-1:0]  touch_key,
   output logic             touch_hit,
   output logic [KEYW-1:0]  lru_key,
   output logic [DATAW-1:0] lru_data,
   output logic             empty,
   output logic             full,
   output logic             alm_full,
   output logic [SIZEW-1:0] size
`ifdef LRU_KEY_QUEUE_PERF_EN
   ,
   output logic [31:0]      perf_touch_hits,
   output logic [31:0]      perf_touch_misses,
   output logic [31:0]      perf_refreshes
`endif
);

   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [IDXW-1:0] ord_t [DEPTH];

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [KEYW-1:0]  key_q  [DEPTH];
   logic [KEYW-1:0]  key_d  [DEPTH];
   logic [DATAW-1:0] data_q [DEPTH];
   logic [DATAW-1:0] data_d [DEPTH];
   ord_t             ord_q, ord_d;
   logic [SIZEW-1:0] size_q, size_d;

   logic            t_hit, p_hit, p_live, pop_ok, ins_block;
   logic [IDXW-1:0] t_slot, p_slot, lru_slot, free_slot;

`ifdef LRU_KEY_QUEUE_PERF_EN
   logic [31:0] hits_q, hits_d, misses_q, misses_d, refr_q, refr_d;
`endif

   // Remove slot s from the first n positions of o and re-append it at MRU.
   function automatic ord_t to_mru(input ord_t o, input logic [SIZEW-1:0] n,
                                   input logic [IDXW-1:0] s);
      ord_t            r;
      logic [IDXW-1:0] j;
      logic [SIZEW-1:0] last;
      r    = o;
      j    = '0;
      last = n - 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(n) && o[i] != s) begin
            r[j] = o[i];
            j    = j + 1'b1;
         end
      end
      r[last[IDXW-1:0]] = s;
      return r;
   endfunction

   // Key lookups against pre-edge state, valid slots only.
   always_comb begin
      t_hit  = 1'b0;
      t_slot = '0;
      p_hit  = 1'b0;
      p_slot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && key_q[i] == touch_key) begin
            t_hit  = 1'b1;
            t_slot = IDXW'(i);
         end
         if (valid_q[i] && key_q[i] == push_key) begin
            p_hit  = 1'b1;
            p_slot = IDXW'(i);
         end
      end
   end

   // Next-state: pop, then touch, then push, all in one edge.
   always_comb begin
      valid_d   = valid_q;
      key_d     = key_q;
      data_d    = data_q;
      ord_d     = ord_q;
      size_d    = size_q;
      free_slot = '0;
      lru_slot  = ord_q[0];
      pop_ok    = pop && (size_q != '0);
      p_live    = p_hit && !(pop_ok && p_slot == lru_slot);
      ins_block = push && !p_hit && !pop_ok && (size_q == SIZEW'(DEPTH));
      if (!ins_block) begin
         if (pop_ok) begin
            valid_d[lru_slot] = 1'b0;
            for (int i = 0; i < DEPTH - 1; i++) ord_d[i] = ord_q[i+1];
            size_d = size_q - 1'b1;
         end
         if (touch && t_hit && !(pop_ok && t_slot == lru_slot))
            ord_d = to_mru(ord_d, size_d, t_slot);
         if (push) begin
            if (p_live) begin
               data_d[p_slot] = push_data;
               ord_d          = to_mru(ord_d, size_d, p_slot);
            end else begin
               for (int i = DEPTH - 1; i >= 0; i--)
                  if (!valid_d[i]) free_slot = IDXW'(i);
               valid_d[free_slot]          = 1'b1;
               key_d[free_slot]            = push_key;
               data_d[free_slot]           = push_data;
               ord_d[size_d[IDXW-1:0]]     = free_slot;
               size_d                      = size_d + 1'b1;
            end
         end
      end
   end

`ifdef LRU_KEY_QUEUE_PERF_EN
   // Event counters; a touch dropped by a same-cycle pop still counts as a hit.
   always_comb begin
      hits_d   = hits_q + {31'd0, touch && t_hit};
      misses_d = misses_q + {31'd0, touch && !t_hit};
      refr_d   = refr_q + {31'd0, push && p_live};
   end
`endif

   // State registers; slot key/data need no reset since valid gates them.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         size_q  <= '0;
         for (int i = 0; i < DEPTH; i++) ord_q[i] <= '0;
`ifdef LRU_KEY_QUEUE_PERF_EN
         hits_q   <= '0;
         misses_q <= '0;
         refr_q   <= '0;
`endif
      end else begin
         valid_q <= valid_d;
         size_q  <= size_d;
         ord_q   <= ord_d;
         key_q   <= key_d;
         data_q  <= data_d;
`ifdef LRU_KEY_QUEUE_PERF_EN
         hits_q   <= hits_d;
         misses_q <= misses_d;
         refr_q   <= refr_d;
`endif
      end
   end

   // Outputs read registered state.
   always_comb begin
      touch_hit = touch && t_hit;
      empty     = (size_q == '0);
      full      = (size_q == SIZEW'(DEPTH));
      alm_full  = (size_q >= SIZEW'(ALM_FULL));
      size      = size_q;
      lru_key   = empty ? '0 : key_q[ord_q[0]];
      lru_data  = empty ? '0 : data_q[ord_q[0]];
   end

`ifdef LRU_KEY_QUEUE_PERF_EN
   assign perf_touch_hits   = hits_q;
   assign perf_touch_misses = misses_q;
   assign perf_refreshes    = refr_q;
`endif

endmodule

// File: tb/tb_lru_key_queue.sv
// Bench for lru_key_queue: directed scenarios followed by random traffic,
// checked against a queue-based LRU model (front = LRU, back = MRU).
module tb_lru_key_queue;
   localparam int DEPTH = 4;
   localparam int KEYW  = 16;
   localparam int DATAW = 32;
   localparam int SIZEW = 3;
   localparam int ALM   = DEPTH - 1;

   localparam logic [15:0] KA = 16'h000A, KB = 16'h000B, KC = 16'h000C,
                           KD = 16'h000D, KE = 16'h000E, KF = 16'h000F,
                           KZ = 16'h0077, KY = 16'h0078;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, push, pop, touch;
   logic [KEYW-1:0]  push_key, touch_key;
   logic [DATAW-1:0] push_data;
   logic             touch_hit, empty, full, alm_full;
   logic [KEYW-1:0]  lru_key;
   logic [DATAW-1:0] lru_data;
   logic [SIZEW-1:0] size;
`ifdef LRU_KEY_QUEUE_PERF_EN
   logic [31:0] perf_touch_hits, perf_touch_misses, perf_refreshes;
`endif

   lru_key_queue #(.DATAW(DATAW), .KEYW(KEYW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .push(push), .push_key(push_key),
      .push_data(push_data), .pop(pop), .touch(touch), .touch_key(touch_key),
      .touch_hit(touch_hit), .lru_key(lru_key), .lru_data(lru_data),
      .empty(empty), .full(full), .alm_full(alm_full), .size(size)
`ifdef LRU_KEY_QUEUE_PERF_EN
      , .perf_touch_hits(perf_touch_hits), .perf_touch_misses(perf_touch_misses),
      .perf_refreshes(perf_refreshes)
`endif
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [KEYW-1:0]  mk[$];
   logic [DATAW-1:0] md[$];
   int unsigned m_hits, m_miss, m_ref;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int find_key(input logic [KEYW-1:0] k);
      foreach (mk[i]) if (mk[i] == k) return i;
      return -1;
   endfunction

   task automatic check_state();
      int n;
      n = mk.size();
      chk("size", 64'(size), 64'(n));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("full", 64'(full), 64'(n == DEPTH));
      chk("alm_full", 64'(alm_full), 64'(n >= ALM));
      chk("lru_key", 64'(lru_key), (n > 0) ? 64'(mk[0]) : 64'd0);
      chk("lru_data", 64'(lru_data), (n > 0) ? 64'(md[0]) : 64'd0);
`ifdef LRU_KEY_QUEUE_PERF_EN
      chk("perf_hits", 64'(perf_touch_hits), 64'(m_hits));
      chk("perf_misses", 64'(perf_touch_misses), 64'(m_miss));
      chk("perf_refreshes", 64'(perf_refreshes), 64'(m_ref));
`endif
   endtask

   // One clock: drive, check combinational hit, advance model, check state.
   task automatic cyc(input logic p, input logic [KEYW-1:0] pk, input logic [DATAW-1:0] pd,
                      input logic po, input logic t, input logic [KEYW-1:0] tk);
      int ti, pi;
      bit illegal;
      logic [KEYW-1:0]  k;
      logic [DATAW-1:0] d;
      @(negedge clk);
      push = p; push_key = pk; push_data = pd; pop = po; touch = t; touch_key = tk;
      #1;
      ti = find_key(tk);
      chk("touch_hit", 64'(touch_hit), 64'(t && ti >= 0));
      if (t) begin
         if (ti >= 0) m_hits++;
         else m_miss++;
      end
      illegal = p && mk.size() == DEPTH && !po && find_key(pk) < 0;
      if (!illegal) begin
         if (po && mk.size() > 0) begin
            void'(mk.pop_front());
            void'(md.pop_front());
         end
         if (t) begin
            ti = find_key(tk);
            if (ti >= 0) begin
               k = mk[ti]; d = md[ti];
               mk.delete(ti); md.delete(ti);
               mk.push_back(k); md.push_back(d);
            end
         end
         if (p) begin
            pi = find_key(pk);
            if (pi >= 0) begin
               mk.delete(pi); md.delete(pi);
               m_ref++;
            end
            mk.push_back(pk); md.push_back(pd);
         end
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      push = 1'b1; push_key = KA; push_data = 32'h1234; pop = 1'b1; touch = 1'b1; touch_key = KA;
      @(posedge clk);
      #1;
      reset = 1'b0;
      push = 1'b0; pop = 1'b0; touch = 1'b0;
      mk.delete(); md.delete();
      m_hits = 0; m_miss = 0; m_ref = 0;
      check_state();
   endtask

   task automatic idle();
      cyc(1'b0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      reset = 1'b0; push = 1'b0; pop = 1'b0; touch = 1'b0;
      push_key = '0; push_data = '0; touch_key = '0;
      m_hits = 0; m_miss = 0; m_ref = 0;

      // Fill A..D, then touch B and drain three.
      do_reset();
      cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);           // pop on empty: ignored
      cyc(1'b1, KA, 32'hA0, 1'b0, 1'b0, '0);
      cyc(1'b1, KB, 32'hB0, 1'b0, 1'b0, '0);
      cyc(1'b1, KC, 32'hC0, 1'b0, 1'b0, '0);
      chk("tp_alm_after_3", 64'(alm_full), 64'd1);
      cyc(1'b1, KD, 32'hD0, 1'b0, 1'b0, '0);
      chk("tp_full", 64'(full), 64'd1);
      chk("tp_lru_A", 64'(lru_key), 64'(KA));
      cyc(1'b0, '0, '0, 1'b0, 1'b1, KB);
      chk("tp_pop1_A", 64'(lru_key), 64'(KA));
      cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
      chk("tp_pop2_C", 64'(lru_key), 64'(KC));
      cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
      chk("tp_pop3_D", 64'(lru_key), 64'(KD));
      cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
      chk("tp_rem_B", 64'(lru_key), 64'(KB));
      chk("tp_size1", 64'(size), 64'd1);

      // Insert with pop on full, then illegal insert on full.
      do_reset();
      cyc(1'b1, KA, 32'hA0, 1'b0, 1'b0, '0);
      cyc(1'b1, KB, 32'hB0, 1'b0, 1'b0, '0);
      cyc(1'b1, KC, 32'hC0, 1'b0, 1'b0, '0);
      cyc(1'b1, KD, 32'hD0, 1'b0, 1'b0, '0);
      cyc(1'b1, KE, 32'hE0, 1'b1, 1'b0, '0);
      chk("tp_pushpop_lru_B", 64'(lru_key), 64'(KB));
      cyc(1'b1, KF, 32'hF0, 1'b0, 1'b0, '0);
      chk("tp_illegal_size", 64'(size), 64'd4);
      chk("tp_illegal_lru", 64'(lru_key), 64'(KB));
      cyc(1'b1, KC, 32'hC1, 1'b0, 1'b0, '0);       // refresh on full
      repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);

      // Refresh moves A to MRU with new data.
      do_reset();
      cyc(1'b1, KA, 32'hA0, 1'b0, 1'b0, '0);
      cyc(1'b1, KB, 32'hB0, 1'b0, 1'b0, '0);
      cyc(1'b1, KC, 32'hC0, 1'b0, 1'b0, '0);
      cyc(1'b1, KA, 32'h55, 1'b0, 1'b0, '0);
      chk("tp_refresh_size", 64'(size), 64'd3);
      cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
      chk("tp_refresh_data", 64'(lru_data), 64'h55);

      // Touch of LRU dropped by same-cycle pop, miss, touch+push same key, reset.
      do_reset();
      cyc(1'b1, KA, 32'hA0, 1'b0, 1'b0, '0);
      cyc(1'b1, KB, 32'hB0, 1'b0, 1'b0, '0);
      cyc(1'b0, '0, '0, 1'b1, 1'b1, KA);
      chk("tp_drop_lru_B", 64'(lru_key), 64'(KB));
      cyc(1'b0, '0, '0, 1'b0, 1'b1, KZ);
      cyc(1'b1, KC, 32'hC0, 1'b0, 1'b0, '0);
      cyc(1'b1, KB, 32'hB9, 1'b0, 1'b1, KB);
      cyc(1'b1, KA, 32'hA1, 1'b0, 1'b1, KC);
      do_reset();
      chk("tp_reset_empty", 64'(empty), 64'd1);

      // Counter scenario: 3 hits, 2 misses, 1 refresh, then reset.
      cyc(1'b1, KA, 32'hA0, 1'b0, 1'b0, '0);
      cyc(1'b1, KB, 32'hB0, 1'b0, 1'b0, '0);
      cyc(1'b0, '0, '0, 1'b0, 1'b1, KA);
      cyc(1'b0, '0, '0, 1'b0, 1'b1, KB);
      cyc(1'b0, '0, '0, 1'b0, 1'b1, KA);
      cyc(1'b0, '0, '0, 1'b0, 1'b1, KZ);
      cyc(1'b0, '0, '0, 1'b0, 1'b1, KY);
      cyc(1'b1, KB, 32'hB5, 1'b0, 1'b0, '0);
`ifdef LRU_KEY_QUEUE_PERF_EN
      chk("tp_perf_hits3", 64'(perf_touch_hits), 64'd3);
      chk("tp_perf_miss2", 64'(perf_touch_misses), 64'd2);
      chk("tp_perf_ref1", 64'(perf_refreshes), 64'd1);
      do_reset();
      chk("tp_perf_clr", 64'(perf_touch_hits | perf_touch_misses | perf_refreshes), 64'd0);
`endif

      // Random traffic over a small key space.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         else cyc(1'($urandom_range(0, 99) < 45), 16'($urandom_range(1, 6)), $urandom,
                  1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 40),
                  16'($urandom_range(1, 7)));
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
